// File: rtl/seq_mul_arbiter.sv
// Round-robin front end that time-shares one sequential multiplier core among
// NREQ requesters: clear core, launch it, wait for ready (with timeout), respond.
module seq_mul_arbiter #(
  parameter int N       = 4,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 31
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*N-1:0]   op_a,
  input  logic [NREQ*N-1:0]   op_b,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     rsp_valid,
  output logic [2*N-1:0]      rsp_product,
  output logic                rsp_error,
  output logic                busy,
  output logic                mul_rst,
  output logic                mul_start,
  output logic [N-1:0]        mul_multiplicand,
  output logic [N-1:0]        mul_multiplier,
  input  logic                mul_ready,
  input  logic [2*N-1:0]      mul_product
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_LAUNCH, S_WAIT, S_RESP} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic [2*N-1:0]  prod_q, prod_d;
  logic            err_q, err_d;

  logic            found;
  logic [PW-1:0]   pick;

  // Rotating priority: first asserted request at or above ptr, wrapping.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    found = 1'b0;
    pick  = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: if (found) begin
        state_d = S_CLR;
        owner_d = pick;
        a_d     = op_a[int'(pick)*N +: N];
        b_d     = op_b[int'(pick)*N +: N];
      end
      S_CLR:    state_d = S_LAUNCH;
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Ready is only trusted here; the core was cleared in CLR.
        if (mul_ready) begin
          prod_d  = mul_product;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          prod_d  = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        ptr_d   = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    gnt       = '0;
    rsp_valid = '0;
    if (state_q == S_CLR)  gnt[owner_q]       = 1'b1;
    if (state_q == S_RESP) rsp_valid[owner_q] = 1'b1;
  end

  assign busy             = (state_q != S_IDLE);
  assign mul_rst          = rst | (state_q == S_CLR);
  assign mul_start        = (state_q == S_LAUNCH);
  assign mul_multiplicand = a_q;
  assign mul_multiplier   = b_q;
  assign rsp_product      = prod_q;
  assign rsp_error        = err_q;

endmodule
